// File: rtl/aq_fdsu_pkg.sv
// Shared definitions for the fdsu fraction-shift blocks.
//   fsm_state_e : iterative shifter state encoding (IDLE/SHIFT/DONE)
//   DEF_*       : default parameter constants for the shifter
package aq_fdsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } fsm_state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 5;
  localparam int DEF_STEP  = 4;
  localparam int DEF_BIAS  = 8;

endpackage

// File: rtl/aq_fdsu_rshift_step.sv
// One iteration of the fraction right shifter (purely combinational).
//   i_data      : current fraction
//   i_remaining : bits still to be shifted
//   o_step      : bits shifted this iteration = min(i_remaining, STEP)
//   o_data      : i_data >> o_step, zero fill
//   o_sticky    : OR of the bits shifted out this iteration
module aq_fdsu_rshift_step #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  parameter int CNT_W = 5
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [CNT_W-1:0] i_remaining,
  output logic [CNT_W-1:0] o_step,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sticky
);

  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  logic [WIDTH-1:0] w_mask;

  assign o_step   = (i_remaining > STEP_C) ? STEP_C : i_remaining;
  assign o_data   = i_data >> o_step;
  // Low o_step bits set: exactly the bits that fall off the bottom.
  assign w_mask   = ~({WIDTH{1'b1}} << o_step);
  assign o_sticky = |(i_data & w_mask);

endmodule

// File: rtl/aq_fdsu_rshift_iter.sv
// Iterative fraction right shifter with sticky collection.
// Shifts in_data right by the effective count, at most STEP bits per cycle,
// and ORs every bit shifted out into out_sticky.
//   cpuclk, cpurst       : clock, synchronous active-high reset
//   in_vld/in_rdy        : request handshake
//   in_data, in_sft_cnt  : fraction and shift count
//   in_inv               : 0 = shift by cnt, 1 = shift by BIAS - cnt (clamped at 0)
//   flush                : abort any operation on the next edge
//   out_vld/out_rdy      : result handshake
//   out_data, out_sticky : shifted fraction and sticky bit
//   busy                 : state is not IDLE
//   dbg_state            : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its payload stable while valid is high and
// ready is low. in_rdy is only high in IDLE without flush, and out_vld is
// only high in DONE.
module aq_fdsu_rshift_iter
  import aq_fdsu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int STEP  = DEF_STEP,
  parameter int BIAS  = DEF_BIAS
) (
  input  logic             cpuclk,
  input  logic             cpurst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_sft_cnt,
  input  logic             in_inv,
  input  logic             flush,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic             busy,
  output fsm_state_e       dbg_state
);

  localparam logic [CNT_W-1:0] BIAS_C  = CNT_W'(BIAS);
  localparam logic [31:0]      WIDTH_U = 32'(WIDTH);

  fsm_state_e       r_state;
  fsm_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_sticky;
  logic [CNT_W-1:0] r_remaining;

  logic [CNT_W-1:0] w_eff;
  logic             w_eff_zero;
  logic             w_eff_sat;
  logic             w_accept;
  logic [CNT_W-1:0] w_step;
  logic [WIDTH-1:0] w_step_data;
  logic             w_step_sticky;
  logic [CNT_W-1:0] w_rem_nxt;

  // Complement mode clamps at zero rather than wrapping.
  assign w_eff = in_inv ? ((in_sft_cnt > BIAS_C) ? '0 : (BIAS_C - in_sft_cnt))
                        : in_sft_cnt;
  assign w_eff_zero = (w_eff == '0);
  assign w_eff_sat  = (32'(w_eff) >= WIDTH_U);

  assign in_rdy   = (r_state == ST_IDLE) & ~flush;
  assign w_accept = in_vld & in_rdy;

  aq_fdsu_rshift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .CNT_W (CNT_W)
  ) u_step (
    .i_data      (r_data),
    .i_remaining (r_remaining),
    .o_step      (w_step),
    .o_data      (w_step_data),
    .o_sticky    (w_step_sticky)
  );

  // Never underflows: w_step <= r_remaining by construction.
  assign w_rem_nxt = r_remaining - w_step;

  always_ff @(posedge cpuclk) begin
    if (cpurst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_state_nxt = (w_eff_zero | w_eff_sat) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_rem_nxt == '0) begin
            w_state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_rdy) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge cpuclk) begin
    if (cpurst) begin
      r_data      <= '0;
      r_sticky    <= 1'b0;
      r_remaining <= '0;
    end else if (!flush) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_eff_zero) begin
              r_data      <= in_data;
              r_sticky    <= 1'b0;
              r_remaining <= '0;
            end else if (w_eff_sat) begin
              r_data      <= '0;
              r_sticky    <= |in_data;
              r_remaining <= '0;
            end else begin
              r_data      <= in_data;
              r_sticky    <= 1'b0;
              r_remaining <= w_eff;
            end
          end
        end
        ST_SHIFT: begin
          r_data      <= w_step_data;
          r_sticky    <= r_sticky | w_step_sticky;
          r_remaining <= w_rem_nxt;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_vld    = (r_state == ST_DONE);
  assign out_data   = r_data;
  assign out_sticky = r_sticky;
  assign busy       = (r_state != ST_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_aq_fdsu_rshift_iter.sv
module tb_aq_fdsu_rshift_iter;
  import aq_fdsu_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam int STEP  = 4;
  localparam int BIAS  = 8;

  logic             cpuclk;
  logic             cpurst;
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] in_sft_cnt;
  logic             in_inv;
  logic             flush;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;
  logic             busy;
  fsm_state_e       dbg_state;

  int vectors;
  int miscompares;

  // {sticky, data} of each accepted request, in order
  logic [WIDTH:0] exp_q[$];

  aq_fdsu_rshift_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .STEP  (STEP),
    .BIAS  (BIAS)
  ) dut (
    .cpuclk     (cpuclk),
    .cpurst     (cpurst),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .in_data    (in_data),
    .in_sft_cnt (in_sft_cnt),
    .in_inv     (in_inv),
    .flush      (flush),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial cpuclk = 1'b0;
  always #5 cpuclk = ~cpuclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] data,
                                           input int cnt, input logic inv,
                                           output int lat);
    int eff;
    int d;
    logic [WIDTH-1:0] r;
    logic s;
    d = int'(data);
    if (inv) eff = (cnt > BIAS) ? 0 : BIAS - cnt;
    else     eff = cnt;
    if (eff == 0) begin
      r = data; s = 1'b0; lat = 1;
    end else if (eff >= WIDTH) begin
      r = '0; s = (d != 0); lat = 1;
    end else begin
      r = WIDTH'(d / (1 << eff));
      s = ((d % (1 << eff)) != 0);
      lat = (eff + STEP - 1) / STEP + 1;
    end
    return {s, r};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge cpuclk) begin
    if (!cpurst && out_vld) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_vld", 32'(out_vld), 32'd0);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q[0][WIDTH-1:0]));
        check("out_sticky", 32'(out_sticky), 32'(exp_q[0][WIDTH]));
        check("busy_in_done", 32'(busy), 32'd1);
        if (out_rdy) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [WIDTH-1:0] data, input logic [CNT_W-1:0] cnt,
                        input logic inv, output bit ok);
    int guard;
    @(posedge cpuclk); #1;
    in_vld = 1'b1; in_data = data; in_sft_cnt = cnt; in_inv = inv;
    @(negedge cpuclk);
    guard = 0;
    while (!in_rdy && guard < 50) begin
      @(negedge cpuclk);
      guard++;
    end
    ok = in_rdy;
    if (!ok) begin
      check("accept_timeout", 32'(in_rdy), 32'd1);
      in_vld = 1'b0;
    end else begin
      @(posedge cpuclk);
      #1;
      // garbage outside the accept cycle must be ignored
      in_vld = 1'b0;
      in_data = WIDTH'($urandom);
      in_sft_cnt = CNT_W'($urandom);
      in_inv = 1'($urandom);
    end
  endtask

  task automatic do_req(input logic [WIDTH-1:0] data, input logic [CNT_W-1:0] cnt,
                        input logic inv, input int hold,
                        input logic [WIDTH-1:0] e_data, input logic e_sticky,
                        input int e_lat);
    int lat;
    bit ok;
    accept(data, cnt, inv, ok);
    if (!ok) return;
    exp_q.push_back({e_sticky, e_data});
    lat = 1;
    @(negedge cpuclk);
    while (!out_vld && lat < 40) begin
      @(negedge cpuclk);
      lat++;
    end
    check("latency", 32'(lat), 32'(e_lat));
    if (!out_vld) begin
      exp_q.delete();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge cpuclk); #1;
      in_vld = 1'($urandom);
      in_data = WIDTH'($urandom);
      in_sft_cnt = CNT_W'($urandom);
      @(negedge cpuclk);
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_in_rdy", 32'(in_rdy), 32'd0);
    end
    @(posedge cpuclk); #1;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    @(posedge cpuclk); #1;
    out_rdy = 1'b0;
    @(negedge cpuclk);
    check("idle_in_rdy", 32'(in_rdy), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_out_vld", 32'(out_vld), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_rdy"}, 32'(in_rdy), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_out_vld"}, 32'(out_vld), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH:0] m;
    logic [WIDTH-1:0] rd;
    logic [CNT_W-1:0] rc;
    logic ri;
    int ml;
    bit ok;

    vectors = 0; miscompares = 0;
    cpurst = 1'b1; in_vld = 1'b0; in_data = '0; in_sft_cnt = '0; in_inv = 1'b0;
    flush = 1'b0; out_rdy = 1'b0;
    repeat (3) @(posedge cpuclk);
    #1 cpurst = 1'b0;
    @(negedge cpuclk);
    check_idle("reset");
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_sticky", 32'(out_sticky), 32'd0);

    // model pinned against hand-computed values
    m = model(16'hABCD, 0, 1'b1, ml);
    check("model_bias", 32'(m), 32'h100AB);
    check("model_bias_lat", 32'(ml), 32'd3);
    m = model(16'h0001, 20, 1'b0, ml);
    check("model_sat", 32'(m), 32'h10000);

    // directed cases with literal expectations
    do_req(16'hABCD, 5'd0,  1'b1, 0, 16'h00AB, 1'b1, 3);
    do_req(16'h8001, 5'd7,  1'b1, 0, 16'h4000, 1'b1, 2);
    do_req(16'h5A5A, 5'd10, 1'b1, 1, 16'h5A5A, 1'b0, 1);
    do_req(16'h1234, 5'd0,  1'b0, 0, 16'h1234, 1'b0, 1);
    do_req(16'h0001, 5'd20, 1'b0, 0, 16'h0000, 1'b1, 1);
    do_req(16'h0000, 5'd16, 1'b0, 0, 16'h0000, 1'b0, 1);
    do_req(16'h8000, 5'd15, 1'b0, 0, 16'h0001, 1'b0, 5);
    do_req(16'hFFF0, 5'd5,  1'b0, 5, 16'h07FF, 1'b1, 3);

    // flush one cycle into SHIFT
    accept(16'hFFFF, 5'd13, 1'b0, ok);
    @(posedge cpuclk); #1 flush = 1'b1;
    @(posedge cpuclk); #1 flush = 1'b0;
    @(negedge cpuclk);
    check_idle("flush");
    repeat (8) @(negedge cpuclk);
    do_req(16'hFFFF, 5'd13, 1'b0, 0, 16'h0007, 1'b1, 5);

    // reset one cycle into SHIFT
    accept(16'hFFFF, 5'd13, 1'b0, ok);
    @(posedge cpuclk); #1 cpurst = 1'b1;
    @(posedge cpuclk); #1 cpurst = 1'b0;
    @(negedge cpuclk);
    check_idle("midrst");
    check("midrst_out_data", 32'(out_data), 32'd0);
    repeat (8) @(negedge cpuclk);
    do_req(16'hFFFF, 5'd13, 1'b0, 0, 16'h0007, 1'b1, 5);

    // randomized requests against the model
    for (int n = 0; n < 150; n++) begin
      rd = WIDTH'($urandom);
      rc = CNT_W'($urandom_range(0, 31));
      ri = 1'($urandom_range(0, 1));
      m = model(rd, int'(rc), ri, ml);
      do_req(rd, rc, ri, $urandom_range(0, 3), m[WIDTH-1:0], m[WIDTH], ml);
    end

    repeat (4) @(negedge cpuclk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aq_fdsu_rshift_iter.md
AQ_FDSU_RSHIFT_ITER -- requirements
Module: aq_fdsu_rshift_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, fraction datapath width.
REQ-002 SHALL have parameter CNT_W, default 5, shift-count width.
REQ-003 SHALL have parameter STEP, default 4, maximum bits shifted per cycle; must be a power of 2 and no greater than WIDTH.
REQ-004 SHALL have parameter BIAS, default 8, base used in complement mode.
REQ-005 SHALL have one clock and one synchronous, active-high reset, with ports as below:
- cpuclk  in  1  clock; all state updates on the rising edge.
- cpurst  in  1  reset; synchronous, active-high.
- in_vld  in  1  request valid.
- in_rdy  out  1  request accepted when high with in_vld.
- in_data  in  WIDTH  fraction to shift.
- in_sft_cnt  in  CNT_W  shift count.
- in_inv  in  1  count mode; 0 = direct, 1 = complement (BIAS - cnt).
- flush  in  1  abort the operation in progress.
- out_vld  out  1  result valid.
- out_rdy  in  1  result consumed when high with out_vld.
- out_data  out  WIDTH  shifted fraction.
- out_sticky  out  1  OR of all bits shifted out.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-006 SHALL compute the effective shift eff = in_inv ? (BIAS - in_sft_cnt) : in_sft_cnt, clamping eff to 0 when in_inv=1 and in_sft_cnt > BIAS.
REQ-007 SHALL produce out_data = in_data >> eff (logical, zero-fill) and out_sticky = OR of in_data[eff-1:0], with out_sticky = 0 when eff = 0.
REQ-008 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-009 SHALL drive in_rdy = (state==IDLE) & ~flush; a request is accepted on in_vld & in_rdy.
REQ-010 On accept with eff=0, SHALL go to DONE with data unchanged and sticky 0.
REQ-011 On accept with eff >= WIDTH, SHALL go to DONE with data 0 and sticky = |in_data.
REQ-012 On accept otherwise, SHALL go to SHIFT, register in_data, set remaining = eff and clear sticky.
REQ-013 In SHIFT, each cycle SHALL apply step = min(remaining, STEP): data >>= step, sticky |= the bits shifted out, remaining -= step; it SHALL go to DONE when remaining - step == 0.
REQ-014 SHALL drive out_vld = (state==DONE); out_data and out_sticky SHALL hold stable while out_vld & ~out_rdy.
REQ-015 On out_vld & out_rdy, SHALL go to IDLE; in_rdy is high in the following cycle, so there is no back-to-back accept.
REQ-016 Latency, accept edge to first out_vld cycle: 1 cycle for eff=0 or eff>=WIDTH; otherwise ceil(eff/STEP)+1 cycles.
REQ-017 flush SHALL take effect on the next edge from any state: go to IDLE, out_vld low, no result emitted.
- flush wins over a simultaneous accept or out handshake.
REQ-018 in_* inputs SHALL be ignored outside the accept cycle.
REQ-019 All arithmetic on remaining SHALL be CNT_W bits wide and SHALL not underflow (guaranteed by min()).

Reset
REQ-020 On cpurst=1 at an edge, SHALL set state = IDLE, out_data = 0, out_sticky = 0 and remaining = 0, giving out_vld = 0, busy = 0 and in_rdy = 1 when flush is low.
REQ-021 Reset SHALL override flush and any handshake in the same cycle; an operation cut off mid-shift by reset SHALL produce no output.

Structure
REQ-022 SHALL take its FSM state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and default parameter constants from the shared fdsu package/header aq_fdsu_pkg.
REQ-023 SHALL instantiate one combinational sub-module, aq_fdsu_rshift_step (parameters WIDTH, STEP, CNT_W), which computes the one-step shifted data and the shifted-out sticky bit for a given step.

Verification (WIDTH=16, CNT_W=5, STEP=4, BIAS=8)
REQ-024 Complement mode, BIAS shift: in_data=0xABCD, cnt=0, inv=1 (eff=8) -> out_data=0x00AB, out_sticky=1, out_vld 3 cycles after accept.
REQ-025 Complement mode, single-bit shift and clamp:
- in_data=0x8001, cnt=7, inv=1 (eff=1) -> 0x4000, sticky=1, latency 2.
- cnt=10, inv=1 -> eff=0 (clamped).
REQ-026 Direct mode, zero and saturating shifts, all latency 1:
- inv=0, cnt=0, in_data=0x1234 -> 0x1234, sticky=0.
- cnt=20, in_data=0x0001 -> 0x0000, sticky=1.
- cnt=16, in_data=0x0000 -> 0x0000, sticky=0.
REQ-027 Backpressure: eff=5, in_data=0xFFF0, out_rdy low for 5 cycles -> out_data=0x07FF and sticky=1 held stable, busy=1, in_rdy=0, in_vld pulses ignored; IDLE one cycle after out_rdy rises.
REQ-028 Flush and reset mid-shift:
- eff=13, in_data=0xFFFF, flush one cycle into SHIFT -> out_vld never rises, in_rdy=1 next cycle.
- Next request eff=13 -> 0x0007, sticky=1, latency 5.
- Repeat with cpurst instead of flush -> same recovery.
